// File: rtl/zynq_axi_arb_pkg.sv
// Shared types and AXI3 sideband constants for the two-requester m00_axi arbiter.
package zynq_axi_arb_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2
    } wr_state_e;

    localparam logic [1:0] AXI_LOCK_C  = 2'b00;
    localparam logic [3:0] AXI_CACHE_C = 4'b0011;
    localparam logic [2:0] AXI_PROT_C  = 3'b000;
    localparam logic [3:0] AXI_QOS_C   = 4'h0;

    // A lone requester always wins; the pointer only breaks ties.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        if (req == 2'b11) return ptr;
        return req[1];
    endfunction

endpackage

// File: rtl/zynq_axi_master_arb2_if.sv
// AXI3 channel bundle (no sidebands, no wid) used for both requester and m00 ports.
interface zynq_axi_master_arb2_if #(
    parameter int id_width_p   = 6,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int len_width_p  = 4
);
    logic [addr_width_p-1:0]   awaddr;
    logic [id_width_p-1:0]     awid;
    logic [len_width_p-1:0]    awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;

    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [id_width_p-1:0]     bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [addr_width_p-1:0]   araddr;
    logic [id_width_p-1:0]     arid;
    logic [len_width_p-1:0]    arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;

    logic [data_width_p-1:0]   rdata;
    logic [id_width_p-1:0]     rid;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output araddr, arid, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rid, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awid, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input araddr, arid, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rid, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/bsg_arb_round_robin.sv
// Two-way round-robin picker; the pointer moves only when the owner reports a completed grant.
module bsg_arb_round_robin
    import zynq_axi_arb_pkg::*;
#(
    parameter int width_p  = 2,
    parameter bit toggle_p = 1'b0
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [width_p-1:0] reqs_i,
    input  logic               update_i,
    input  logic               favour_i,
    output logic               grant_o
);

    logic ptrQ_q, ptr_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ptrQ_q <= 1'b0;
        else          ptrQ_q <= ptr_d;
    end

    // toggle_p flips on every grant; otherwise the owner names the side to favour next.
    always_comb begin
        ptr_d = ptrQ_q;
        if (update_i) ptr_d = toggle_p ? ~ptrQ_q : favour_i;
    end

    assign grant_o = rr_pick(reqs_i, ptrQ_q);

endmodule

// File: rtl/zynq_axi_master_arb2.sv
// Shares the PL-to-PS m00_axi AXI3 master between two requesters; the ID MSB records the source.
module zynq_axi_master_arb2
    import zynq_axi_arb_pkg::*;
#(
    parameter int id_width_p   = 6,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int len_width_p  = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    zynq_axi_master_arb2_if.slave  s0_axi,
    zynq_axi_master_arb2_if.slave  s1_axi,
    zynq_axi_master_arb2_if.master m00_axi,
    output logic [id_width_p-1:0] m00_axi_wid_o,
    output logic [1:0]            m00_axi_awlock_o,
    output logic [1:0]            m00_axi_arlock_o,
    output logic [3:0]            m00_axi_awcache_o,
    output logic [3:0]            m00_axi_arcache_o,
    output logic [2:0]            m00_axi_awprot_o,
    output logic [2:0]            m00_axi_arprot_o,
    output logic [3:0]            m00_axi_awqos_o,
    output logic [3:0]            m00_axi_arqos_o
);

    wr_state_e             state_q, state_d;
    logic                  wsrc_q, wsrc_d;
    logic [id_width_p-2:0] wid_q, wid_d;
    logic                  ar_lock_q, ar_lock_d, ar_src_q;
    logic                  aw_grant, ar_grant, ar_sel, ar_fire, wr_done, bsel, rsel;
    logic [1:0]            awvalid, wvalid, arvalid, awready, wready, arready;

    assign awvalid = {s1_axi.awvalid, s0_axi.awvalid};
    assign wvalid  = {s1_axi.wvalid,  s0_axi.wvalid};
    assign arvalid = {s1_axi.arvalid, s0_axi.arvalid};

    bsg_arb_round_robin #(.width_p(2), .toggle_p(1'b0)) aw_rr (
        .aclk(aclk), .aresetn(aresetn), .reqs_i(awvalid),
        .update_i(wr_done), .favour_i(~wsrc_q), .grant_o(aw_grant)
    );

    bsg_arb_round_robin #(.width_p(2), .toggle_p(1'b1)) ar_rr (
        .aclk(aclk), .aresetn(aresetn), .reqs_i(arvalid),
        .update_i(ar_fire), .favour_i(1'b0), .grant_o(ar_grant)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= WR_IDLE;
            wsrc_q  <= 1'b0;
            wid_q   <= '0;
        end else begin
            state_q <= state_d;
            wsrc_q  <= wsrc_d;
            wid_q   <= wid_d;
        end
    end

    assign wr_done = (state_q == WR_DATA) & m00_axi.wvalid & m00_axi.wready & m00_axi.wlast;

    always_comb begin
        state_d = state_q;
        wsrc_d  = wsrc_q;
        wid_d   = wid_q;
        case (state_q)
            WR_IDLE: if (|awvalid) begin
                wsrc_d  = aw_grant;
                state_d = WR_ADDR;
            end
            WR_ADDR: if (awvalid[wsrc_q] & m00_axi.awready) begin
                wid_d   = wsrc_q ? s1_axi.awid : s0_axi.awid;
                state_d = WR_DATA;
            end
            WR_DATA: if (wr_done) state_d = WR_IDLE;
            default: state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        m00_axi.awvalid = 1'b0;
        m00_axi.wvalid  = 1'b0;
        awready         = '0;
        wready          = '0;
        case (state_q)
            WR_ADDR: begin
                m00_axi.awvalid = awvalid[wsrc_q];
                awready[wsrc_q] = m00_axi.awready & awvalid[wsrc_q];
            end
            WR_DATA: begin
                m00_axi.wvalid = wvalid[wsrc_q];
                wready[wsrc_q] = m00_axi.wready;
            end
            default: ;
        endcase
    end

    assign m00_axi.awaddr  = wsrc_q ? s1_axi.awaddr  : s0_axi.awaddr;
    assign m00_axi.awid    = {wsrc_q, (wsrc_q ? s1_axi.awid : s0_axi.awid)};
    assign m00_axi.awlen   = wsrc_q ? s1_axi.awlen   : s0_axi.awlen;
    assign m00_axi.awsize  = wsrc_q ? s1_axi.awsize  : s0_axi.awsize;
    assign m00_axi.awburst = wsrc_q ? s1_axi.awburst : s0_axi.awburst;
    assign m00_axi.wdata   = wsrc_q ? s1_axi.wdata   : s0_axi.wdata;
    assign m00_axi.wstrb   = wsrc_q ? s1_axi.wstrb   : s0_axi.wstrb;
    assign m00_axi.wlast   = wsrc_q ? s1_axi.wlast   : s0_axi.wlast;
    assign m00_axi_wid_o   = {wsrc_q, wid_q};

    // A stalled AR keeps its source so a newly arriving requester cannot swap the address under valid.
    assign ar_sel          = ar_lock_q ? ar_src_q : ar_grant;
    assign m00_axi.arvalid = arvalid[ar_sel];
    assign ar_fire         = m00_axi.arvalid & m00_axi.arready;
    assign ar_lock_d       = m00_axi.arvalid & ~m00_axi.arready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_lock_q <= 1'b0;
            ar_src_q  <= 1'b0;
        end else begin
            ar_lock_q <= ar_lock_d;
            ar_src_q  <= ar_sel;
        end
    end

    always_comb begin
        arready         = '0;
        arready[ar_sel] = m00_axi.arready & arvalid[ar_sel];
    end

    assign m00_axi.araddr  = ar_sel ? s1_axi.araddr  : s0_axi.araddr;
    assign m00_axi.arid    = {ar_sel, (ar_sel ? s1_axi.arid : s0_axi.arid)};
    assign m00_axi.arlen   = ar_sel ? s1_axi.arlen   : s0_axi.arlen;
    assign m00_axi.arsize  = ar_sel ? s1_axi.arsize  : s0_axi.arsize;
    assign m00_axi.arburst = ar_sel ? s1_axi.arburst : s0_axi.arburst;

    assign s0_axi.awready = awready[0];
    assign s1_axi.awready = awready[1];
    assign s0_axi.wready  = wready[0];
    assign s1_axi.wready  = wready[1];
    assign s0_axi.arready = arready[0];
    assign s1_axi.arready = arready[1];

    assign bsel           = m00_axi.bid[id_width_p-1];
    assign s0_axi.bvalid  = m00_axi.bvalid & ~bsel;
    assign s1_axi.bvalid  = m00_axi.bvalid & bsel;
    assign s0_axi.bid     = m00_axi.bid[id_width_p-2:0];
    assign s1_axi.bid     = m00_axi.bid[id_width_p-2:0];
    assign s0_axi.bresp   = m00_axi.bresp;
    assign s1_axi.bresp   = m00_axi.bresp;
    assign m00_axi.bready = bsel ? s1_axi.bready : s0_axi.bready;

    assign rsel           = m00_axi.rid[id_width_p-1];
    assign s0_axi.rvalid  = m00_axi.rvalid & ~rsel;
    assign s1_axi.rvalid  = m00_axi.rvalid & rsel;
    assign s0_axi.rid     = m00_axi.rid[id_width_p-2:0];
    assign s1_axi.rid     = m00_axi.rid[id_width_p-2:0];
    assign s0_axi.rdata   = m00_axi.rdata;
    assign s1_axi.rdata   = m00_axi.rdata;
    assign s0_axi.rresp   = m00_axi.rresp;
    assign s1_axi.rresp   = m00_axi.rresp;
    assign s0_axi.rlast   = m00_axi.rlast;
    assign s1_axi.rlast   = m00_axi.rlast;
    assign m00_axi.rready = rsel ? s1_axi.rready : s0_axi.rready;

    assign m00_axi_awlock_o  = AXI_LOCK_C;
    assign m00_axi_arlock_o  = AXI_LOCK_C;
    assign m00_axi_awcache_o = AXI_CACHE_C;
    assign m00_axi_arcache_o = AXI_CACHE_C;
    assign m00_axi_awprot_o  = AXI_PROT_C;
    assign m00_axi_arprot_o  = AXI_PROT_C;
    assign m00_axi_awqos_o   = AXI_QOS_C;
    assign m00_axi_arqos_o   = AXI_QOS_C;

endmodule

// File: tb/tb_zynq_axi_master_arb2.sv
// Directed bench for zynq_axi_master_arb2: inputs change on negedge, outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_zynq_axi_master_arb2;

    logic aclk = 1'b0;
    logic aresetn;
    int   vectors = 0;
    int   miscompares = 0;

    logic [5:0] mWid;
    logic [1:0] awLock, arLock;
    logic [3:0] awCache, arCache, awQos, arQos;
    logic [2:0] awProt, arProt;

    zynq_axi_master_arb2_if #(.id_width_p(5)) s0 ();
    zynq_axi_master_arb2_if #(.id_width_p(5)) s1 ();
    zynq_axi_master_arb2_if #(.id_width_p(6)) m ();

    always #5 aclk = ~aclk;

    zynq_axi_master_arb2 #(
        .id_width_p(6), .addr_width_p(32), .data_width_p(32), .len_width_p(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axi(s0), .s1_axi(s1), .m00_axi(m),
        .m00_axi_wid_o(mWid),
        .m00_axi_awlock_o(awLock), .m00_axi_arlock_o(arLock),
        .m00_axi_awcache_o(awCache), .m00_axi_arcache_o(arCache),
        .m00_axi_awprot_o(awProt), .m00_axi_arprot_o(arProt),
        .m00_axi_awqos_o(awQos), .m00_axi_arqos_o(arQos)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_inputs();
        s0.awvalid = 1'b0; s0.awaddr = '0; s0.awid = '0; s0.awlen = '0; s0.awsize = 3'd2; s0.awburst = 2'b01;
        s0.wvalid = 1'b0; s0.wdata = '0; s0.wstrb = '1; s0.wlast = 1'b0; s0.bready = 1'b0;
        s0.arvalid = 1'b0; s0.araddr = '0; s0.arid = '0; s0.arlen = '0; s0.arsize = 3'd2; s0.arburst = 2'b01; s0.rready = 1'b0;
        s1.awvalid = 1'b0; s1.awaddr = '0; s1.awid = '0; s1.awlen = '0; s1.awsize = 3'd2; s1.awburst = 2'b01;
        s1.wvalid = 1'b0; s1.wdata = '0; s1.wstrb = '1; s1.wlast = 1'b0; s1.bready = 1'b0;
        s1.arvalid = 1'b0; s1.araddr = '0; s1.arid = '0; s1.arlen = '0; s1.arsize = 3'd2; s1.arburst = 2'b01; s1.rready = 1'b0;
        m.awready = 1'b0; m.wready = 1'b0; m.bvalid = 1'b0; m.bid = '0; m.bresp = '0; m.arready = 1'b0;
        m.rvalid = 1'b0; m.rid = '0; m.rdata = '0; m.rresp = '0; m.rlast = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        clear_inputs();
        m.awready = 1'b1; m.wready = 1'b1; m.arready = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        vectors++; if (m.awvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_awvalid got %b want 0", m.awvalid); end
        vectors++; if (m.wvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_wvalid got %b want 0", m.wvalid); end
        vectors++; if (m.arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_arvalid got %b want 0", m.arvalid); end
        vectors++; if ({s1.awready, s0.awready} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_awready got %b want 00", {s1.awready, s0.awready}); end
        vectors++; if ({s1.wready, s0.wready} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_wready got %b want 00", {s1.wready, s0.wready}); end
        vectors++; if ({s1.arready, s0.arready} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_arready got %b want 00", {s1.arready, s0.arready}); end
        vectors++; if ({s1.bvalid, s0.bvalid, s1.rvalid, s0.rvalid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_brvalid got %b want 0000", {s1.bvalid, s0.bvalid, s1.rvalid, s0.rvalid}); end
        vectors++; if (mWid !== 6'd0) begin miscompares++; $display("[TB] FAIL rst_wid got %h want 00", mWid); end
        vectors++; if ({awLock, arLock, awCache, arCache} !== 12'b0000_0011_0011) begin miscompares++; $display("[TB] FAIL sideband_lock_cache got %b want 000000110011", {awLock, arLock, awCache, arCache}); end
        vectors++; if ({awProt, arProt, awQos, arQos} !== 14'd0) begin miscompares++; $display("[TB] FAIL sideband_prot_qos got %b want 0", {awProt, arProt, awQos, arQos}); end
        aresetn = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge aclk);
        s0.awvalid = 1'b1; s0.awaddr = 32'h1000_0000; s0.awid = 5'b00101; s0.awlen = 4'd3;
        #1;
        vectors++; if (m.awvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_aw_latency got %b want 0", m.awvalid); end
        @(negedge aclk); #1;
        vectors++; if (m.awvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_awvalid got %b want 1", m.awvalid); end
        vectors++; if (m.awaddr !== 32'h1000_0000) begin miscompares++; $display("[TB] FAIL sw_awaddr got %h want 10000000", m.awaddr); end
        vectors++; if (m.awid !== 6'b000101) begin miscompares++; $display("[TB] FAIL sw_awid got %b want 000101", m.awid); end
        vectors++; if (m.awlen !== 4'd3) begin miscompares++; $display("[TB] FAIL sw_awlen got %0d want 3", m.awlen); end
        vectors++; if (s0.awready !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_awready_low got %b want 0", s0.awready); end
        m.awready = 1'b1; #1;
        vectors++; if (s0.awready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_awready_high got %b want 1", s0.awready); end
        @(negedge aclk);
        s0.awvalid = 1'b0; m.awready = 1'b0; m.wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0.wvalid = 1'b1; s0.wdata = 32'hA000_0000 + i; s0.wlast = (i == 3);
            #1;
            vectors++; if (m.wvalid !== 1'b1 || m.wdata !== 32'hA000_0000 + i) begin miscompares++; $display("[TB] FAIL sw_wbeat%0d got v=%b d=%h want v=1 d=%h", i, m.wvalid, m.wdata, 32'hA000_0000 + i); end
            vectors++; if (m.wlast !== (i == 3) || s0.wready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_wlast_ready%0d got last=%b rdy=%b", i, m.wlast, s0.wready); end
            vectors++; if (mWid !== 6'b000101) begin miscompares++; $display("[TB] FAIL sw_wid%0d got %b want 000101", i, mWid); end
            @(negedge aclk);
        end
        s0.wvalid = 1'b0; s0.wlast = 1'b0; #1;
        vectors++; if (m.wvalid !== 1'b0 || s0.wready !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_burst_end got v=%b rdy=%b want 0 0", m.wvalid, s0.wready); end
        m.bvalid = 1'b1; m.bid = 6'b000101; m.bresp = 2'b00; s0.bready = 1'b1; #1;
        vectors++; if (s0.bvalid !== 1'b1 || s1.bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_b_route got s0=%b s1=%b want 1 0", s0.bvalid, s1.bvalid); end
        vectors++; if (s0.bid !== 5'b00101 || m.bready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_b_id got bid=%b bready=%b want 00101 1", s0.bid, m.bready); end
        @(negedge aclk);
        m.bvalid = 1'b0; s0.bready = 1'b0;
    endtask

    task automatic test_both_aw_stall();
        do_reset();
        @(negedge aclk);
        s0.awvalid = 1'b1; s0.awaddr = 32'h100; s0.awid = 5'd1; s0.awlen = 4'd1;
        s1.awvalid = 1'b1; s1.awaddr = 32'h200; s1.awid = 5'd2; s1.awlen = 4'd0;
        s1.wvalid = 1'b1; s1.wdata = 32'hBBBB_0000; s1.wlast = 1'b1;
        m.wready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk); #1;
            vectors++; if (m.awvalid !== 1'b1 || m.awaddr !== 32'h100 || m.awid !== 6'b000001) begin miscompares++; $display("[TB] FAIL stall%0d_aw got v=%b a=%h id=%b want 1 100 000001", c, m.awvalid, m.awaddr, m.awid); end
            vectors++; if (s1.awready !== 1'b0 || s1.wready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall%0d_s1 got awrdy=%b wrdy=%b want 0 0", c, s1.awready, s1.wready); end
        end
        m.awready = 1'b1; #1;
        vectors++; if ({s1.awready, s0.awready} !== 2'b01) begin miscompares++; $display("[TB] FAIL both_aw_grant got %b want 01", {s1.awready, s0.awready}); end
        @(negedge aclk);
        s0.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s0.wvalid = 1'b1; s0.wdata = 32'h11 + i; s0.wlast = (i == 1);
            #1;
            vectors++; if (m.wdata !== 32'h11 + i || s0.wready !== 1'b1) begin miscompares++; $display("[TB] FAIL both_s0_w%0d got d=%h rdy=%b want %h 1", i, m.wdata, s0.wready, 32'h11 + i); end
            vectors++; if (s1.wready !== 1'b0 || s1.awready !== 1'b0) begin miscompares++; $display("[TB] FAIL both_s1_blocked%0d got wrdy=%b awrdy=%b want 0 0", i, s1.wready, s1.awready); end
            @(negedge aclk);
        end
        s0.wvalid = 1'b0; s0.wlast = 1'b0; #1;
        vectors++; if (m.awvalid !== 1'b0 || m.wvalid !== 1'b0 || s1.wready !== 1'b0) begin miscompares++; $display("[TB] FAIL both_idle_gap got aw=%b w=%b s1wrdy=%b want 0 0 0", m.awvalid, m.wvalid, s1.wready); end
        @(negedge aclk); #1;
        vectors++; if (m.awvalid !== 1'b1 || m.awid !== 6'b100010 || m.awaddr !== 32'h200) begin miscompares++; $display("[TB] FAIL both_s1_aw got v=%b id=%b a=%h want 1 100010 200", m.awvalid, m.awid, m.awaddr); end
        vectors++; if (s1.awready !== 1'b1) begin miscompares++; $display("[TB] FAIL both_s1_awready got %b want 1", s1.awready); end
        @(negedge aclk);
        s1.awvalid = 1'b0; #1;
        vectors++; if (s1.wready !== 1'b1 || m.wdata !== 32'hBBBB_0000 || m.wlast !== 1'b1) begin miscompares++; $display("[TB] FAIL both_s1_w got rdy=%b d=%h last=%b want 1 bbbb0000 1", s1.wready, m.wdata, m.wlast); end
        vectors++; if (mWid !== 6'b100010) begin miscompares++; $display("[TB] FAIL both_s1_wid got %b want 100010", mWid); end
        @(negedge aclk);
        s1.wvalid = 1'b0; s1.wlast = 1'b0; m.awready = 1'b0;
    endtask

    task automatic test_reads();
        logic [5:0]  expId [4];
        logic [31:0] expAddr [4];
        expId   = '{6'h03, 6'h24, 6'h03, 6'h24};
        expAddr = '{32'h300, 32'h400, 32'h304, 32'h404};
        do_reset();
        @(negedge aclk);
        m.arready = 1'b1;
        s0.arvalid = 1'b1; s0.araddr = 32'h300; s0.arid = 5'd3;
        s1.arvalid = 1'b1; s1.araddr = 32'h400; s1.arid = 5'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (m.arvalid !== 1'b1 || m.arid !== expId[i] || m.araddr !== expAddr[i]) begin miscompares++; $display("[TB] FAIL ar%0d got v=%b id=%h a=%h want 1 %h %h", i, m.arvalid, m.arid, m.araddr, expId[i], expAddr[i]); end
            vectors++; if ({s1.arready, s0.arready} !== (expId[i][5] ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL ar%0d_ready got %b", i, {s1.arready, s0.arready}); end
            @(negedge aclk);
            case (i)
                0: s0.araddr = 32'h304;
                1: s1.araddr = 32'h404;
                2: s0.arvalid = 1'b0;
                default: s1.arvalid = 1'b0;
            endcase
        end
        #1;
        vectors++; if (m.arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_drained got %b want 0", m.arvalid); end
        m.arready = 1'b0;
        s1.arvalid = 1'b1; s1.araddr = 32'h500; s1.arid = 5'd5;
        @(negedge aclk);
        s0.arvalid = 1'b1; s0.araddr = 32'h600; s0.arid = 5'd3; #1;
        vectors++; if (m.arid !== 6'b100101 || m.araddr !== 32'h500 || s0.arready !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_lock got id=%b a=%h s0rdy=%b want 100101 500 0", m.arid, m.araddr, s0.arready); end
        m.arready = 1'b1; #1;
        vectors++; if (s1.arready !== 1'b1) begin miscompares++; $display("[TB] FAIL ar_lock_release got %b want 1", s1.arready); end
        @(negedge aclk);
        s1.arvalid = 1'b0; #1;
        vectors++; if (m.arid !== 6'b000011 || m.araddr !== 32'h600) begin miscompares++; $display("[TB] FAIL ar_after_lock got id=%b a=%h want 000011 600", m.arid, m.araddr); end
        @(negedge aclk);
        s0.arvalid = 1'b0; m.arready = 1'b0;
    endtask

    task automatic test_r_routing();
        logic [5:0]  rId [4];
        logic [31:0] rData [4];
        logic        expDst [4];
        rId    = '{6'h24, 6'h03, 6'h25, 6'h06};
        rData  = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
        expDst = '{1'b1, 1'b0, 1'b1, 1'b0};
        s0.rready = 1'b1; s1.rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m.rvalid = 1'b1; m.rid = rId[i]; m.rdata = rData[i]; m.rlast = 1'b1;
            #1;
            vectors++; if ({s1.rvalid, s0.rvalid} !== (expDst[i] ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL r%0d_route got %b", i, {s1.rvalid, s0.rvalid}); end
            vectors++; if ((expDst[i] ? s1.rdata : s0.rdata) !== rData[i] || (expDst[i] ? s1.rid : s0.rid) !== rId[i][4:0] || m.rready !== 1'b1) begin miscompares++; $display("[TB] FAIL r%0d_beat got d=%h rready=%b want %h 1", i, expDst[i] ? s1.rdata : s0.rdata, m.rready, rData[i]); end
            @(negedge aclk);
        end
        m.rvalid = 1'b1; m.rid = 6'h24; m.rdata = 32'hE5E5_0001; s1.rready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (m.rready !== 1'b0 || s1.rvalid !== 1'b1 || s1.rdata !== 32'hE5E5_0001 || s0.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL r_bp%0d got mrdy=%b v=%b d=%h s0v=%b", c, m.rready, s1.rvalid, s1.rdata, s0.rvalid); end
            @(negedge aclk);
        end
        s1.rready = 1'b1; #1;
        vectors++; if (m.rready !== 1'b1 || s1.rdata !== 32'hE5E5_0001) begin miscompares++; $display("[TB] FAIL r_bp_release got mrdy=%b d=%h want 1 e5e50001", m.rready, s1.rdata); end
        @(negedge aclk);
        m.rvalid = 1'b0; s0.rready = 1'b0; s1.rready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        @(negedge aclk);
        s0.awvalid = 1'b1; s0.awaddr = 32'h800; s0.awid = 5'd9; s0.awlen = 4'd3;
        m.awready = 1'b1; m.wready = 1'b1;
        repeat (2) @(negedge aclk);
        s0.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s0.wvalid = 1'b1; s0.wdata = i; s0.wlast = 1'b0;
            @(negedge aclk);
        end
        s0.wdata = 32'd2; #1;
        vectors++; if (m.wvalid !== 1'b1 || mWid !== 6'b001001) begin miscompares++; $display("[TB] FAIL mid_beat2 got v=%b wid=%b want 1 001001", m.wvalid, mWid); end
        aresetn = 1'b0; #1;
        vectors++; if (m.wvalid !== 1'b0 || s0.wready !== 1'b0 || m.awvalid !== 1'b0 || s0.awready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_outputs got w=%b wrdy=%b aw=%b awrdy=%b want 0", m.wvalid, s0.wready, m.awvalid, s0.awready); end
        vectors++; if (mWid !== 6'd0) begin miscompares++; $display("[TB] FAIL mid_reset_wid got %b want 000000", mWid); end
        clear_inputs();
        @(negedge aclk);
        aresetn = 1'b1;
        s1.awvalid = 1'b1; s1.awaddr = 32'h700; s1.awid = 5'd7; s1.awlen = 4'd0; m.awready = 1'b1;
        @(negedge aclk); #1;
        vectors++; if (m.awvalid !== 1'b1 || m.awid !== 6'b100111 || s1.awready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_aw got v=%b id=%b rdy=%b want 1 100111 1", m.awvalid, m.awid, s1.awready); end
        @(negedge aclk);
        s1.awvalid = 1'b0; s1.wvalid = 1'b1; s1.wdata = 32'hCAFE; s1.wlast = 1'b1; m.wready = 1'b1; #1;
        vectors++; if (s1.wready !== 1'b1 || mWid !== 6'b100111 || m.wdata !== 32'hCAFE) begin miscompares++; $display("[TB] FAIL post_reset_w got rdy=%b wid=%b d=%h want 1 100111 cafe", s1.wready, mWid, m.wdata); end
        @(negedge aclk);
        clear_inputs();
    endtask

    initial begin
        $display("[TB] starting zynq_axi_master_arb2 directed tests");
        test_reset();
        test_single_write();
        test_both_aw_stall();
        test_reads();
        test_r_routing();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
